// File: rtl/line_buffer_pkg.sv
// ---------------------------------------------------------------------------
// line_buffer_pkg
// Shared constants and helpers for the line buffer slice.
//   DEF_*     : default parameter values for line_buffer and line_buffer_if
//   BANK_W    : width of bank and line counters (enough for up to 7 banks)
//   bank_mod  : non-negative modulo used to pick the bank feeding each tap
// ---------------------------------------------------------------------------
package line_buffer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LINE_WIDTH = 640;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_NUM_LINES  = 3;

    localparam int BANK_W = 3;

    // Tap selection subtracts a line offset from the write bank, which can go
    // negative, so the plain % operator would return a negative index.
    function automatic int bank_mod(input int value, input int modulus);
        int r;
        r = value % modulus;
        if (r < 0) begin
            r = r + modulus;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_buffer_if.sv
// ---------------------------------------------------------------------------
// line_buffer_if
// Pixel stream in, vertical tap column out.
//   sof, in_valid, in_data          : raster pixel stream (master drives)
//   out_valid, out_taps, out_col,
//   eol                             : tap column stream (slave drives)
// ---------------------------------------------------------------------------
interface line_buffer_if
    import line_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_LINES  = DEF_NUM_LINES
) ();

    logic                            sof;
    logic                            in_valid;
    logic [DATA_WIDTH-1:0]           in_data;
    logic                            out_valid;
    logic [NUM_LINES*DATA_WIDTH-1:0] out_taps;
    logic [ADDR_WIDTH-1:0]           out_col;
    logic                            eol;

    modport master (
        output sof, in_valid, in_data,
        input  out_valid, out_taps, out_col, eol
    );

    modport slave (
        input  sof, in_valid, in_data,
        output out_valid, out_taps, out_col, eol
    );

endinterface

// File: rtl/line_ram.sv
// ---------------------------------------------------------------------------
// line_ram
// Single-clock simple dual-port RAM holding one image line.
//   clk, rst_n           : clock, synchronous active-low reset (output reg only)
//   we_i, wr_addr_i,
//   wr_data_i            : write port
//   rd_en_i, rd_addr_i   : read port; read-first when addresses collide
//   rd_data_o            : registered read data, holds when rd_en_i is low
// ---------------------------------------------------------------------------
module line_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdData_q;

    // Storage is never reset; the line counter upstream keeps stale data from
    // ever being flagged valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking read in the same edge as the write returns the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdData_q <= '0;
        end else if (rd_en_i) begin
            rdData_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// Delivers a vertical column of NUM_LINES pixels per accepted pixel, using
// NUM_LINES-1 line RAMs written round-robin.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   bus      : line_buffer_if slave (sof/in_valid/in_data in,
//              out_valid/out_taps/out_col/eol out, one cycle latency)
// ---------------------------------------------------------------------------
module line_buffer
    import line_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic          clk,
    input  logic          rst_n,
    line_buffer_if.slave  bus
);

    localparam int NB     = NUM_LINES - 1;
    localparam int RAM_AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(LINE_WIDTH - 1);
    localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(NB - 1);
    localparam logic [BANK_W-1:0]     TOP_LINE  = BANK_W'(NUM_LINES - 1);

    logic                  accept;
    logic                  restart;
    logic [ADDR_WIDTH-1:0] colEff;
    logic [BANK_W-1:0]     bankEff;
    logic [BANK_W-1:0]     lineEff;
    logic [RAM_AW-1:0]     ramAddr;

    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [BANK_W-1:0]     line_q, line_d;

    logic [DATA_WIDTH-1:0] tap0_q, tap0_d;
    logic [BANK_W-1:0]     bankSel_q, bankSel_d;
    logic                  outValid_q, outValid_d;
    logic                  eol_q, eol_d;
    logic [ADDR_WIDTH-1:0] outCol_q, outCol_d;

    logic [DATA_WIDTH-1:0]           ramRd [NB];
    logic [NUM_LINES*DATA_WIDTH-1:0] tapsW;

    assign accept  = bus.in_valid;
    assign restart = bus.in_valid & bus.sof;

    // An accepted sof pixel is column 0 of line 0, so the counters are forced
    // to zero before they address the RAMs in the same cycle.
    assign colEff  = restart ? '0 : col_q;
    assign bankEff = restart ? '0 : bank_q;
    assign lineEff = restart ? '0 : line_q;
    assign ramAddr = colEff[RAM_AW-1:0];

    // Column/bank/line advance; the line counter saturates once enough history
    // exists, and that saturation is what gates out_valid.
    always_comb begin
        col_d      = col_q;
        bank_d     = bank_q;
        line_d     = line_q;
        tap0_d     = tap0_q;
        bankSel_d  = bankSel_q;
        outCol_d   = outCol_q;
        outValid_d = 1'b0;
        eol_d      = 1'b0;
        if (accept) begin
            tap0_d     = bus.in_data;
            bankSel_d  = bankEff;
            outCol_d   = colEff;
            outValid_d = (lineEff == TOP_LINE);
            eol_d      = (lineEff == TOP_LINE) && (colEff == LAST_COL);
            if (colEff == LAST_COL) begin
                col_d  = '0;
                bank_d = (bankEff == LAST_BANK) ? '0 : bankEff + BANK_W'(1);
                line_d = (lineEff == TOP_LINE) ? TOP_LINE : lineEff + BANK_W'(1);
            end else begin
                col_d  = colEff + ADDR_WIDTH'(1);
                bank_d = bankEff;
                line_d = lineEff;
            end
        end
    end

    // Counter and output registers; RAM contents are deliberately untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q      <= '0;
            bank_q     <= '0;
            line_q     <= '0;
            tap0_q     <= '0;
            bankSel_q  <= '0;
            outValid_q <= 1'b0;
            eol_q      <= 1'b0;
            outCol_q   <= '0;
        end else begin
            col_q      <= col_d;
            bank_q     <= bank_d;
            line_q     <= line_d;
            tap0_q     <= tap0_d;
            bankSel_q  <= bankSel_d;
            outValid_q <= outValid_d;
            eol_q      <= eol_d;
            outCol_q   <= outCol_d;
        end
    end

    // Every bank is read on every accepted pixel; only the current bank is
    // written, and its read-first output is the oldest line.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (LINE_WIDTH),
            .ADDR_WIDTH (RAM_AW)
        ) u_ram (
            .clk       (clk),
            .rst_n     (rst_n),
            .we_i      (accept && (bankEff == BANK_W'(b))),
            .wr_addr_i (ramAddr),
            .wr_data_i (bus.in_data),
            .rd_en_i   (accept),
            .rd_addr_i (ramAddr),
            .rd_data_o (ramRd[b])
        );
    end

    // Tap k comes from the bank written k lines before the sampled bank.
    always_comb begin
        tapsW                   = '0;
        tapsW[DATA_WIDTH-1:0]   = tap0_q;
        for (int k = 1; k < NUM_LINES; k++) begin
            for (int b = 0; b < NB; b++) begin
                if (b == bank_mod(int'(bankSel_q) - k, NB)) begin
                    tapsW[k*DATA_WIDTH +: DATA_WIDTH] = ramRd[b];
                end
            end
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_taps  = tapsW;
    assign bus.out_col   = outCol_q;
    assign bus.eol       = eol_q;

endmodule

// File: tb/tb_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_line_buffer
// Self-checking bench for line_buffer (DATA_WIDTH=8, LINE_WIDTH=4,
// NUM_LINES=3). Expectations come from a constant vector table or from a
// row/column frame model and flow through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_line_buffer;

    localparam int DW = 8;
    localparam int LW = 4;
    localparam int AW = 10;
    localparam int NL = 3;

    typedef struct {
        logic           valid;
        logic           eol;
        logic [AW-1:0]  col;
        logic [NL*DW-1:0] taps;
    } expT;

    typedef struct {
        logic          s;
        logic [DW-1:0] d;
        logic          ev;
        logic [DW-1:0] t0;
        logic [DW-1:0] t1;
        logic [DW-1:0] t2;
        logic          eol;
        logic [AW-1:0] col;
    } vecT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    line_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL)) bus ();

    line_buffer #(
        .DATA_WIDTH (DW),
        .LINE_WIDTH (LW),
        .ADDR_WIDTH (AW),
        .NUM_LINES  (NL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    expT sbQ[$];
    int  errors = 0;
    int  checks = 0;
    vecT vecs[12];

    // Frame model: pixels stored by absolute row since the last sof/reset.
    int            mRow = 0;
    int            mCol = 0;
    logic [DW-1:0] mLines[8][LW];

    logic             seenValid = 1'b0;
    logic [NL*DW-1:0] firstTaps = '0;

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour in terms of image rows, independent of bank rotation.
    task modelStep(input logic s, input logic v, input logic [DW-1:0] d, output expT e);
        e.valid = 1'b0;
        e.eol   = 1'b0;
        e.col   = '0;
        e.taps  = '0;
        if (v) begin
            if (s) begin
                mRow = 0;
                mCol = 0;
            end
            mLines[mRow % 8][mCol] = d;
            e.col   = AW'(mCol);
            e.valid = (mRow >= NL - 1);
            if (e.valid) begin
                e.taps = {mLines[(mRow - 2) % 8][mCol], mLines[(mRow - 1) % 8][mCol], d};
            end
            e.eol = e.valid && (mCol == LW - 1);
            mCol++;
            if (mCol == LW) begin
                mCol = 0;
                mRow++;
            end
        end
    endtask

    // Pops one expectation and compares it with what the DUT shows now.
    task automatic checkOutput();
        expT e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sbQ.pop_front();
        if (bus.out_valid === 1'b1 && !seenValid) begin
            seenValid = 1'b1;
            firstTaps = bus.out_taps;
        end
        check("out_valid", 64'(bus.out_valid), 64'(e.valid));
        check("eol", 64'(bus.eol), 64'(e.eol));
        if (e.valid) begin
            check("out_col", 64'(bus.out_col), 64'(e.col));
            check("out_taps", 64'(bus.out_taps), 64'(e.taps));
        end
    endtask

    // Drives one cycle, queues its expectation, and checks one cycle later.
    task automatic applyStimulus(input logic s, input logic v, input logic [DW-1:0] d,
                                 input logic useVec, input expT vecExp);
        expT me;
        bus.sof      = s;
        bus.in_valid = v;
        bus.in_data  = d;
        modelStep(s, v, d, me);
        sbQ.push_back(useVec ? vecExp : me);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset(input int n);
        rst_n        = 1'b0;
        bus.sof      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_eol", 64'(bus.eol), 64'd0);
        check("rst_out_col", 64'(bus.out_col), 64'd0);
        check("rst_out_taps", 64'(bus.out_taps), 64'd0);
        rst_n = 1'b1;
        mRow  = 0;
        mCol  = 0;
        sbQ.delete();
    endtask

    function automatic expT vecToExp(input vecT v);
        expT e;
        e.valid = v.ev;
        e.eol   = v.eol;
        e.col   = v.col;
        e.taps  = {v.t2, v.t1, v.t0};
        return e;
    endfunction

    initial begin
        expT idleExp;
        expT dummy;
        int  firstIdx;
        int  accepted;
        logic v;

        idleExp = '{valid: 1'b0, eol: 1'b0, col: '0, taps: '0};
        dummy   = idleExp;

        // sof, data, valid, tap0, tap1, tap2, eol, col
        vecs[0]  = '{1'b1, 8'd1,  1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 10'd0};
        vecs[1]  = '{1'b0, 8'd2,  1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 10'd1};
        vecs[2]  = '{1'b0, 8'd3,  1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 10'd2};
        vecs[3]  = '{1'b0, 8'd4,  1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 10'd3};
        vecs[4]  = '{1'b0, 8'd5,  1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 10'd0};
        vecs[5]  = '{1'b0, 8'd6,  1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 10'd1};
        vecs[6]  = '{1'b0, 8'd7,  1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 10'd2};
        vecs[7]  = '{1'b0, 8'd8,  1'b0, 8'd0,  8'd0, 8'd0, 1'b0, 10'd3};
        vecs[8]  = '{1'b0, 8'd9,  1'b1, 8'd9,  8'd5, 8'd1, 1'b0, 10'd0};
        vecs[9]  = '{1'b0, 8'd10, 1'b1, 8'd10, 8'd6, 8'd2, 1'b0, 10'd1};
        vecs[10] = '{1'b0, 8'd11, 1'b1, 8'd11, 8'd7, 8'd3, 1'b0, 10'd2};
        vecs[11] = '{1'b0, 8'd12, 1'b1, 8'd12, 8'd8, 8'd4, 1'b1, 10'd3};

        $display("[TB] reset");
        doReset(2);

        $display("[TB] back-to-back pixels 1..12");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].s, 1'b1, vecs[i].d, 1'b1, vecToExp(vecs[i]));
        end

        $display("[TB] pixels 1..12 with idle cycles between");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].s, 1'b1, vecs[i].d, 1'b1, vecToExp(vecs[i]));
            applyStimulus(1'b0, 1'b0, 8'hEE, 1'b1, idleExp);
        end

        $display("[TB] sof restart mid-line");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i == 0, 1'b1, DW'(21 + i), 1'b0, dummy);
        end
        seenValid = 1'b0;
        firstIdx  = -1;
        for (int j = 0; j < 12; j++) begin
            applyStimulus(j == 0, 1'b1, DW'(40 + j), 1'b0, dummy);
            if (seenValid && firstIdx < 0) begin
                firstIdx = j;
            end
        end
        check("sof_first_valid_index", 64'(firstIdx), 64'd8);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i == 0, 1'b1, DW'(61 + i), 1'b0, dummy);
        end
        doReset(1);
        seenValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(101 + i), 1'b0, dummy);
        end
        check("rst_seen_valid", 64'(seenValid), 64'd1);
        check("rst_first_taps", 64'(firstTaps), 64'({8'd101, 8'd105, 8'd109}));

        $display("[TB] random 20 lines");
        applyStimulus(1'b1, 1'b1, DW'($urandom_range(0, 255)), 1'b0, dummy);
        accepted = 1;
        while (accepted < 20 * LW) begin
            v = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b0, v, DW'($urandom_range(0, 255)), 1'b0, dummy);
            if (v) begin
                accepted++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 The block SHALL have parameter LINE_WIDTH, default 640: pixels per image line; legal range 2 to 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 10: column address width.
REQ-004 The block SHALL have parameter NUM_LINES, default 3: vertical taps delivered per column; legal range 2 to 8.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 The block SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port sof, input, 1 bit: start of frame; qualified by in_valid.
REQ-009 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-010 The block SHALL have port in_data, input, DATA_WIDTH bits: raster-order pixel.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_taps is valid.
REQ-012 The block SHALL have port out_taps, output, NUM_LINES*DATA_WIDTH bits: vertical column; tap k occupies bits [k*DATA_WIDTH +: DATA_WIDTH] and holds the pixel k lines above the current one (tap 0 = current pixel).
REQ-013 The block SHALL have port out_col, output, ADDR_WIDTH bits: column index of out_taps.
REQ-014 The block SHALL have port eol, output, 1 bit: one-cycle pulse with the last column of each line, out_valid-qualified.

Function
REQ-015 The block SHALL store NUM_LINES-1 previous lines in NUM_LINES-1 line RAMs, each LINE_WIDTH x DATA_WIDTH, used as a circular set.
REQ-016 On each accepted pixel (in_valid=1), the block SHALL read all RAMs at col_cnt and write in_data into bank wr_bank at col_cnt in the same cycle, with read-first semantics (the read returns the old content).
REQ-017 The block SHALL place out_taps, out_col and eol one clock after the accepting cycle; latency is exactly 1 cycle.
REQ-018 col_cnt SHALL increment per accepted pixel and wrap from LINE_WIDTH-1 to 0; on the wrap, wr_bank SHALL advance modulo NUM_LINES-1 and line_cnt SHALL increment, saturating at NUM_LINES-1.
REQ-019 The block SHALL route the tap k output from the bank written k lines earlier, i.e. bank (wr_bank - k) mod (NUM_LINES-1), with the bank index sampled at the accepting cycle.
REQ-020 out_valid SHALL be 1 one cycle after an accepted pixel only if line_cnt equaled NUM_LINES-1 at acceptance; otherwise it SHALL be 0.
REQ-021 When in_valid=0, all counters SHALL hold, no RAM write SHALL occur, and out_valid SHALL be 0 on the next cycle; out_taps holds its last value.
REQ-022 When sof=1 with in_valid=1, the pixel SHALL be treated as column 0 of line 0: col_cnt, wr_bank and line_cnt are forced to 0 before the access; sof with in_valid=0 SHALL be ignored.
REQ-023 sof arriving mid-line SHALL abandon the partial line; stale RAM contents SHALL never reach a valid output because line_cnt restarts.
REQ-024 eol SHALL be 1 if and only if out_valid=1 and out_col=LINE_WIDTH-1.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL set col_cnt, wr_bank and line_cnt to 0, out_valid to 0, eol to 0, out_col to 0, and out_taps to 0.
REQ-026 RAM contents SHALL NOT be cleared by reset; correctness relies only on line_cnt gating.
REQ-027 A reset mid-frame SHALL behave as if the next accepted pixel carried sof.

Structure
REQ-028 The package line_buffer_pkg SHALL hold the default parameter constants and a bank-index modulo helper function.
REQ-029 The block SHALL use one sub-module, line_ram: a single-clock simple dual-port RAM with registered read-first output and write enable, instantiated NUM_LINES-1 times through a generate loop.

Verification (DATA_WIDTH=8, LINE_WIDTH=4, NUM_LINES=3)
REQ-030 The bench SHALL drive a reset followed by 12 consecutive pixels with values 1..12 and sof on the first; required response: out_valid stays 0 for the first 8 outputs, then outputs 9..12 present taps {9,5,1},{10,6,2},{11,7,3},{12,8,4} (as tap0,tap1,tap2), with eol on the 12th.
REQ-031 The bench SHALL repeat REQ-030 with in_valid deasserted every other cycle; required response: identical valid outputs, each 1 cycle after its accepting cycle, and out_valid=0 on idle cycles.
REQ-032 The bench SHALL assert sof at pixel 7 (mid-line 2); required response: no out_valid until 8 further pixels after the sof pixel.
REQ-033 The bench SHALL assert rst_n=0 for 1 cycle after pixel 10, then send 12 fresh pixels 101..112; required response: outputs are all 0 immediately after the reset, and the first valid taps are {109,105,101}.
REQ-034 The bench SHALL run 20 lines of random data against a reference model; required response: every valid output matches the model, with out_col sequencing 0..3 and wr_bank rotating correctly through the wrap.
